stream_mux_arb: RTL and testbench
=================================

STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 SHALL have parameter NCH, default 31, meaning number of input channels (legal range 2..64).
REQ-002 SHALL have parameter W, default 2, meaning data width per channel.
REQ-003 SHALL have parameter SELW, default 5, meaning channel-index width, equal to max(1, clog2(NCH)).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, as name, direction, width and meaning:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  arbitration mode; 0 = static select, 1 = round-robin.
- sel  in  SELW  channel index, used in mode 0.
- in_valid  in  NCH  per-channel beat valid.
- in_data  in  NCH*W  channel i occupies bits [i*W +: W].
- in_last  in  NCH  per-channel end-of-packet marker.
- in_ready  out  NCH  per-channel accept.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  W  output beat data.
- out_last  out  1  output end-of-packet.
- out_ch  out  SELW  source channel of the output beat.
- err_sel  out  1  sticky flag: sel out of range.
- err_clr  in  1  clears err_sel.

Function
REQ-006 A single output register SHALL hold out_valid, out_data, out_last and out_ch; load_en = !out_valid || out_ready.
REQ-007 A beat on channel g SHALL be accepted when grant==g && in_valid[g] && load_en; in_ready[g] = (grant==g) && load_en; every other in_ready bit SHALL be 0.
REQ-008 An accepted beat SHALL appear on the outputs the next cycle (latency 1), with out_ch=g.
REQ-009 If load_en=1 and no beat is accepted, out_valid SHALL go to 0; if load_en=0, the output register SHALL hold its value.
REQ-010 FSM states SHALL be IDLE and LOCKED(ch).
- IDLE -> LOCKED(g) on acceptance of a beat with in_last[g]=0.
- LOCKED(g) -> IDLE on acceptance of a beat with in_last[g]=1.
- A single beat with last=1 accepted in IDLE SHALL leave the FSM in IDLE.
REQ-011 In LOCKED(g), grant SHALL be g regardless of mode, sel or other channels' in_valid.
REQ-012 In IDLE with mode=0: grant = sel if sel<NCH; otherwise there SHALL be no grant.
REQ-013 In IDLE with mode=0 and sel>=NCH, err_sel SHALL set on the next edge.
REQ-014 In IDLE with mode=1: grant SHALL be the first i with in_valid[i]=1, searching from rr_ptr upward and wrapping NCH-1 -> 0; if none is valid, there SHALL be no grant.
REQ-015 rr_ptr SHALL update to (g+1) mod NCH on acceptance of a last=1 beat from channel g in mode 1; rr_ptr SHALL NOT change in mode 0.
REQ-016 Changes to mode or sel while LOCKED SHALL be ignored until the FSM returns to IDLE.
REQ-017 err_sel SHALL stay set until err_clr=1 or rst; if err_clr and a new error occur in the same cycle, the set SHALL win.
REQ-018 Simultaneous out_ready=1 and a new acceptance in the same cycle SHALL replace the output beat with no bubble, sustaining 1 beat/cycle.
REQ-019 The block SHALL NOT drop, duplicate or interleave beats of different channels within a packet.

Reset
REQ-020 While rst=1, the following SHALL all be 0, with the FSM in IDLE: out_valid, out_data, out_last, out_ch, err_sel, rr_ptr and in_ready.
REQ-021 Reset asserted mid-packet SHALL discard the lock and any held output beat; the first cycle after reset deasserts SHALL arbitrate from IDLE with rr_ptr=0.

Verification
REQ-022 Mode 0, sel=3, in_valid[3]=1, in_data ch3=2'b10, last=1, out_ready=1 -> next cycle out_valid=1, out_data=2'b10, out_ch=3, in_ready=31'h8 during the accept cycle.
REQ-023 Mode 0, sel=31 (NCH=31), all channels valid -> in_ready=0, out_valid stays 0, err_sel=1 next cycle; err_clr pulse -> err_sel=0.
REQ-024 Mode 1, channels 0, 5 and 30 valid with single-beat packets, out_ready=1 -> out_ch sequence 0, 5, 30, 0 on consecutive cycles.
REQ-025 Mode 0, 3-beat packet on ch12 (last on the 3rd beat), sel switched to 13 after beat 1 -> out_ch=12 for all 3 beats, then ch13 is granted.
REQ-026 out_ready held 0 for 4 cycles with ch1 valid -> out beat held stable and in_ready[1]=0; out_ready=1 -> the held beat retires and the next beat loads in the same cycle.
REQ-027 rst asserted during beat 2 of a 4-beat packet -> all outputs 0 next cycle; after release, mode 1 grants the lowest valid channel starting from 0.

Source files
------------

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   Packet-aware N:1 stream multiplexer with static-select or round-robin
//   arbitration. Once the first beat of a packet is accepted, the channel stays
//   granted until its last beat. This keeps packets from different channels
//   from interleaving.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   mode             0 = static select (sel), 1 = round-robin
//   sel              channel index used in static mode
//   in_valid/in_data/in_last/in_ready
//                    per-channel input streams; channel i data is in_data[i*W +: W]
//   out_valid/out_ready/out_data/out_last/out_ch
//                    registered output stream; out_ch is the source channel
//   err_sel          sticky flag, set when static mode selects a nonexistent channel
//   err_clr          clears err_sel (a simultaneous new error wins)
module stream_mux_arb #(
  parameter int NCH  = 31,
  parameter int W    = 2,
  parameter int SELW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_last,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SELW-1:0]   out_ch,
  output logic              err_sel,
  input  logic              err_clr
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Channel count at one bit wider than an index, so that sel >= NCH can be tested.
  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic [0:0]      state_q, state_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic            lock_mode_q, lock_mode_d;  // mode in force when the packet started
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;

  logic            load_en;
  logic            sel_ok;
  logic            grant_vld;
  logic [SELW-1:0] grant_ch;
  logic [W-1:0]    mux_data;
  logic            mux_last;
  logic            accept;
  logic            eff_mode;

  assign load_en = !out_valid_q || out_ready;
  assign sel_ok  = ({1'b0, sel} < NCH_L);

  // Grant selection: the lock dominates, then static select or round-robin search.
  always_comb begin
    logic [SELW:0] idx;
    logic          found;
    grant_vld = 1'b0;
    grant_ch  = '0;
    found     = 1'b0;
    idx       = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_ch  = lock_ch_q;
    end else if (!mode) begin
      grant_vld = sel_ok;
      grant_ch  = sel_ok ? sel : '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (idx >= NCH_L) idx = idx - NCH_L;
        if (!found && in_valid[idx[SELW-1:0]]) begin
          found    = 1'b1;
          grant_ch = idx[SELW-1:0];
        end
      end
      grant_vld = found;
    end
  end

  // Data and last mux for the granted channel.
  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_ch == SELW'(i)) begin
        mux_data = in_data[i*W +: W];
        mux_last = in_last[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = !rst && grant_vld && load_en && (grant_ch == SELW'(gi));
    end
  endgenerate

  assign accept = |(in_ready & in_valid);

  // A packet keeps the arbitration mode that was in force at its first beat.
  assign eff_mode = (state_q == ST_LOCKED) ? lock_mode_q : mode;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    lock_mode_d = lock_mode_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (accept) begin
      if (mux_last) begin
        state_d = ST_IDLE;
        if (eff_mode) begin
          rr_ptr_d = (grant_ch == SELW'(NCH-1)) ? '0 : grant_ch + 1'b1;
        end
      end else begin
        if (state_q == ST_IDLE) lock_mode_d = mode;
        state_d   = ST_LOCKED;
        lock_ch_d = grant_ch;
      end
    end

    if (load_en) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = mux_data;
        out_last_d = mux_last;
        out_ch_d   = grant_ch;
      end
    end

    // A new error takes priority over the clear.
    err_d = ((state_q == ST_IDLE) && !mode && !sel_ok) || (err_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      lock_mode_q <= 1'b0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      lock_mode_q <= lock_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;
  localparam int NCH = 31;
  localparam int W = 2;
  localparam int SELW = 5;

  logic clk, rst, mode, out_ready, err_clr;
  logic [SELW-1:0] sel;
  logic [NCH-1:0] in_valid, in_last, in_ready;
  logic [NCH*W-1:0] in_data;
  logic out_valid, out_last, err_sel;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_ch;

  stream_mux_arb #(.NCH(NCH), .W(W), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .err_sel(err_sel), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           ch;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reset seen at the most recent rising edge.
  logic rst_edge = 1'b0;
  always @(posedge clk) rst_edge <= rst;

  // Reference model state.
  bit m_locked = 0;
  int m_lk_ch = 0;
  bit m_lk_mode = 0;
  int m_rr = 0;
  bit m_err = 0;
  bit m_outv = 0;

  // Reference model: evaluates the arbitration rules with stable inputs,
  // checks in_ready and err_sel, and queues each accepted beat.
  always @(negedge clk) begin
    int g;
    bit le, acc, eff_mode, set_err;
    logic [NCH-1:0] exp_rdy;
    beat_t b;
    #3;
    if (rst) begin
      check("in_ready_in_reset", longint'(in_ready), 0);
      m_locked = 0; m_lk_ch = 0; m_lk_mode = 0; m_rr = 0; m_err = 0; m_outv = 0;
      q.delete();
    end else begin
      le = !m_outv || out_ready;
      g = -1;
      if (m_locked) g = m_lk_ch;
      else if (!mode) g = (int'(sel) < NCH) ? int'(sel) : -1;
      else begin
        for (int k = 0; k < NCH; k++)
          if (g < 0 && in_valid[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
      end
      exp_rdy = '0;
      if (g >= 0 && le) exp_rdy[g] = 1'b1;
      check("in_ready", longint'(in_ready), longint'(exp_rdy));
      check("err_sel", longint'(err_sel), longint'(m_err));
      acc = (g >= 0) && le && in_valid[g];
      eff_mode = m_locked ? m_lk_mode : mode;
      set_err = !m_locked && !mode && (int'(sel) >= NCH);
      if (le) m_outv = acc;
      if (acc) begin
        b.d = in_data[g*W +: W];
        b.l = in_last[g];
        b.ch = g;
        q.push_back(b);
        if (in_last[g]) begin
          if (eff_mode) m_rr = (g + 1) % NCH;
          m_locked = 0;
        end else begin
          if (!m_locked) m_lk_mode = mode;
          m_locked = 1;
          m_lk_ch = g;
        end
      end
      m_err = set_err || (m_err && !err_clr);
    end
  end

  // Monitor: compares the presented output beat with the oldest expected one.
  always @(negedge clk) begin
    #1;
    if (rst_edge) begin
      check("out_after_reset", longint'({out_valid, out_last, out_ch, out_data}), 0);
      check("err_after_reset", longint'(err_sel), 0);
    end else begin
      check("out_valid", longint'(out_valid), longint'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        check("out_data", longint'(out_data), longint'(q[0].d));
        check("out_last", longint'(out_last), longint'(q[0].l));
        check("out_ch", longint'(out_ch), longint'(q[0].ch));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; mode = 0; sel = '0; in_valid = '0; in_data = '0; in_last = '0;
    out_ready = 1; err_clr = 0;
    ticks(2);
    rst = 0;
    tick();

    // Static select of ch3, single-beat packet.
    sel = 5'd3; in_valid = '0; in_valid[3] = 1'b1; in_last = '1;
    in_data[3*W +: W] = 2'b10;
    tick();
    in_valid = '0;
    ticks(2);

    // Out-of-range select, then clear the error.
    sel = 5'd31; in_valid = '1;
    ticks(3);
    sel = 5'd0; in_valid = '0; err_clr = 1;
    tick();
    err_clr = 0;
    tick();

    // Round-robin over ch0, ch5, ch30.
    mode = 1; in_valid = '0; in_valid[0] = 1; in_valid[5] = 1; in_valid[30] = 1; in_last = '1;
    ticks(5);
    in_valid = '0;
    ticks(2);

    // Three-beat packet on ch12 with sel changed mid-packet.
    mode = 0; sel = 5'd12; in_valid = '0; in_valid[12] = 1; in_valid[13] = 1; in_last = '0;
    tick();
    sel = 5'd13;
    tick();
    in_last[12] = 1;
    tick();
    in_last = '1;
    ticks(2);
    in_valid = '0;
    ticks(2);

    // Backpressure for four cycles on ch1.
    sel = 5'd1; in_valid = '0; in_valid[1] = 1; in_last = '1; in_data[1*W +: W] = 2'b01;
    tick();
    out_ready = 0; in_data[1*W +: W] = 2'b11;
    ticks(4);
    out_ready = 1;
    ticks(2);
    in_valid = '0;
    ticks(2);

    // Reset during beat 2 of a 4-beat packet.
    mode = 1; in_valid = '0; in_valid[7] = 1; in_valid[2] = 1; in_last = '0;
    ticks(2);
    rst = 1;
    tick();
    rst = 0;
    in_last = '1;
    ticks(3);
    in_valid = '0;
    ticks(2);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      sel = SELW'($urandom_range(0, 31));
      for (int i = 0; i < NCH; i++) begin
        in_valid[i] = ($urandom_range(0, 3) == 0);
        in_last[i] = ($urandom_range(0, 2) == 0);
        in_data[i*W +: W] = W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    // Drain.
    rst = 0; in_valid = '0; out_ready = 1; err_clr = 0;
    ticks(4);
    check("drain_empty", longint'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
